// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types for the ROM read-port arbiter: FSM states, grant record and
// the round-robin candidate search.
package jtframe_rom_arb_pkg;

  localparam int MAX_SLOTS = 8;
  localparam int IW        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } grant_t;

  // First set bit of cand at or after start (wrapping at slots); scanned
  // downwards so the lowest distance from start wins.
  function automatic grant_t rr_search(input logic [MAX_SLOTS-1:0] cand,
                                       input logic [IW-1:0]        start,
                                       input int                   slots);
    grant_t        g;
    int            k;
    logic [IW-1:0] kk;
    g = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (i < slots) begin
        k  = (int'(start) + i) % slots;
        kk = k[IW-1:0];
        if (cand[kk]) begin
          g.found = 1'b1;
          g.idx   = kk;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/jtframe_rom_arb_slot.sv
// One requester's last-word cache: tag/valid/data, hit compare and the
// registered data-valid flag.
module jtframe_rom_arb_slot
  import jtframe_rom_arb_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [DW-1:0] fill_data_i,
  output logic          hit_o,
  output logic          ok_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;
  logic          ok_q;

  assign hit_o  = valid_q && (tag_q == addr_i);
  assign ok_o   = ok_q;
  assign data_o = data_q;

  // A flush wins over a fill: data read while the ROM is being reloaded is stale.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      ok_q <= req_i & hit_o & ~flush_i;
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (fill_i) begin
        valid_q <= 1'b1;
        tag_q   <= fill_addr_i;
        data_q  <= fill_data_i;
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters,
// one outstanding access, with a last-word cache per requester.
module jtframe_rom_arb
  import jtframe_rom_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_data,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read
);

  arb_state_e     state_q;
  logic [IW-1:0]  sel_q;
  logic [IW-1:0]  rr_q;
  logic           sdram_req_q;
  logic [AW-1:0]  sdram_addr_q;

  logic [SLOTS-1:0]     hit;
  logic [SLOTS-1:0]     fill;
  logic [MAX_SLOTS-1:0] cand;
  grant_t               grant;
  logic [AW-1:0]        grant_addr;
  logic [IW-1:0]        rr_d;
  logic                 done;

  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

  always_comb begin
    cand             = '0;
    cand[SLOTS-1:0]  = slot_req & ~hit;
    grant            = rr_search(cand, rr_q, SLOTS);
    grant_addr       = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (grant.idx == IW'(k)) grant_addr = slot_addr[k*AW +: AW];
    end
    rr_d = (sel_q == IW'(SLOTS - 1)) ? '0 : sel_q + 1'b1;
    // Ack and data in the same REQ cycle count as a completed access.
    done = !loop_rst && data_rdy &&
           (((state_q == REQ) && sdram_ack) || (state_q == WAIT));
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign fill[gi] = done && (sel_q == IW'(gi));

      jtframe_rom_arb_slot #(
        .AW (AW),
        .DW (DW)
      ) u_slot (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .flush_i     (downloading),
        .req_i       (slot_req[gi]),
        .addr_i      (slot_addr[gi*AW +: AW]),
        .fill_i      (fill[gi]),
        .fill_addr_i (sdram_addr_q),
        .fill_data_i (data_read),
        .hit_o       (hit[gi]),
        .ok_o        (slot_ok[gi]),
        .data_o      (slot_data[gi*DW +: DW])
      );
    end
  endgenerate

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      rr_q         <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!downloading && !loop_rst && grant.found) begin
            sel_q        <= grant.idx;
            sdram_addr_q <= grant_addr;
            sdram_req_q  <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (loop_rst) begin
            sdram_req_q <= 1'b0;
            state_q     <= IDLE;
          end else if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            if (data_rdy) begin
              rr_q    <= rr_d;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (loop_rst) begin
            state_q <= IDLE;
          end else if (data_rdy) begin
            rr_q    <= rr_d;
            state_q <= IDLE;
          end
        end
        default: begin
          sdram_req_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: cycle model of the arbiter/cache rules
// checked every cycle, plus hand-computed checks on each scenario.
module tb_jtframe_rom_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic                clk_rom     = 1'b0;
  logic                rst_n       = 1'b0;
  logic                downloading = 1'b0;
  logic                loop_rst    = 1'b0;
  logic [SLOTS-1:0]    slot_req    = '0;
  logic [SLOTS*AW-1:0] slot_addr   = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_data;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack   = 1'b0;
  logic                data_rdy    = 1'b0;
  logic [DW-1:0]       data_read   = '0;

  always #5 clk_rom = ~clk_rom;

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_data   (slot_data),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_valid [SLOTS];
  logic [AW-1:0] m_tag   [SLOTS];
  logic [DW-1:0] m_data  [SLOTS];
  bit            m_ok    [SLOTS];
  bit            m_hit   [SLOTS];
  bit            m_active, m_acked;
  int            m_slot, m_rr, m_k;
  logic [AW-1:0] m_addr;

  function automatic logic [AW-1:0] addr_of(input int k);
    return slot_addr[k*AW +: AW];
  endfunction

  always @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = '0; m_data[k] = '0; m_ok[k] = 1'b0; m_hit[k] = 1'b0;
      end
      m_active = 1'b0; m_acked = 1'b0; m_slot = 0; m_rr = 0; m_addr = '0; m_k = 0;
    end else begin
      for (int k = 0; k < SLOTS; k++) m_hit[k] = m_valid[k] && (m_tag[k] == addr_of(k));
      for (int k = 0; k < SLOTS; k++) m_ok[k] = slot_req[k] && m_hit[k] && !downloading;
      if (!m_active) begin
        if (!downloading && !loop_rst) begin
          for (int i = 0; i < SLOTS; i++) begin
            m_k = (m_rr + i) % SLOTS;
            if (!m_active && slot_req[m_k] && !m_hit[m_k]) begin
              m_active = 1'b1; m_acked = 1'b0; m_slot = m_k; m_addr = addr_of(m_k);
            end
          end
        end
      end else if (loop_rst) begin
        m_active = 1'b0;
      end else if ((m_acked || sdram_ack) && data_rdy) begin
        if (!downloading) begin
          m_valid[m_slot] = 1'b1; m_tag[m_slot] = m_addr; m_data[m_slot] = data_read;
        end
        m_rr     = (m_slot + 1) % SLOTS;
        m_active = 1'b0;
      end else if (sdram_ack) begin
        m_acked = 1'b1;
      end
      if (downloading) for (int k = 0; k < SLOTS; k++) m_valid[k] = 1'b0;
    end
  end

  always @(negedge clk_rom) begin
    if (started) begin
      check("cyc_sdram_req", 64'(sdram_req), 64'(m_active && !m_acked));
      check("cyc_sdram_addr", 64'(sdram_addr), 64'(m_addr));
      for (int k = 0; k < SLOTS; k++) begin
        check($sformatf("cyc_slot_ok[%0d]", k), 64'(slot_ok[k]), 64'(m_ok[k]));
        check($sformatf("cyc_slot_data[%0d]", k), 64'(slot_data[k*DW +: DW]), 64'(m_data[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    slot_addr[k*AW +: AW] = a;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!sdram_req && n < 50) begin
      tick();
      n++;
    end
    check({name, "_req_seen"}, 64'(sdram_req), 64'd1);
  endtask

  task automatic serve(input string name, input int ad, input int rd,
                       input logic [DW-1:0] d, output logic [AW-1:0] a);
    wait_req(name);
    a = sdram_addr;
    repeat (ad) tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    repeat (rd) tick();
    data_read = d; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
  endtask

  task automatic do_reset();
    slot_req = '0;
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] a;
  logic [AW-1:0] exp_order [5];

  initial begin
    exp_order[0] = 22'h200; exp_order[1] = 22'h210; exp_order[2] = 22'h220;
    exp_order[3] = 22'h230; exp_order[4] = 22'h240;

    tick();
    started = 1'b1;
    tick();
    check("reset_sdram_req", 64'(sdram_req), 64'd0);
    check("reset_sdram_addr", 64'(sdram_addr), 64'd0);
    check("reset_slot_ok", 64'(slot_ok), 64'd0);
    check("reset_slot_data0", 64'(slot_data[0 +: DW]), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single miss then cached hit
    set_addr(0, 22'h000100); slot_req[0] = 1'b1;
    serve("t1", 3, 4, 32'hDEADBEEF, a);
    check("t1_addr", 64'(a), 64'h100);
    tick();
    check("t1_ok", 64'(slot_ok[0]), 64'd1);
    check("t1_data", 64'(slot_data[0 +: DW]), 64'hDEADBEEF);
    slot_req[0] = 1'b0; tick();
    check("t1_ok_drop", 64'(slot_ok[0]), 64'd0);
    slot_req[0] = 1'b1; tick();
    check("t1_rehit_ok", 64'(slot_ok[0]), 64'd1);
    check("t1_rehit_noreq", 64'(sdram_req), 64'd0);

    // 2: round-robin order from a fresh pointer
    do_reset();
    for (int k = 0; k < SLOTS; k++) set_addr(k, 22'h200 + 22'(k * 16));
    slot_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      serve("t2", 1, 1, 32'h2000_0000 + 32'(i), a);
      check($sformatf("t2_grant%0d", i), 64'(a), 64'(exp_order[i]));
      if (i == 0) set_addr(0, 22'h240);
    end
    slot_req = '0; tick();

    // 3: address change while the access is outstanding
    set_addr(1, 22'h10); slot_req = 4'b0010;
    wait_req("t3a");
    check("t3_addr_a", 64'(sdram_addr), 64'h10);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    set_addr(1, 22'h20); tick();
    data_read = 32'h1111_0010; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    tick();
    check("t3_ok_stays", 64'(slot_ok[1]), 64'd0);
    serve("t3b", 0, 0, 32'h1111_0020, a);
    check("t3_addr_b", 64'(a), 64'h20);
    tick();
    check("t3_ok_b", 64'(slot_ok[1]), 64'd1);
    slot_req = '0; tick();

    // 4: download invalidates the cache
    set_addr(2, 22'h400); slot_req = 4'b0100;
    serve("t4a", 1, 1, 32'h0000_4444, a);
    tick();
    check("t4_ok_before", 64'(slot_ok[2]), 64'd1);
    downloading = 1'b1; tick();
    check("t4_ok_dl", 64'(slot_ok[2]), 64'd0);
    tick();
    check("t4_noreq_dl", 64'(sdram_req), 64'd0);
    downloading = 1'b0;
    serve("t4b", 0, 2, 32'h0000_4445, a);
    check("t4_refetch_addr", 64'(a), 64'h400);
    tick();
    check("t4_ok_after", 64'(slot_ok[2]), 64'd1);
    check("t4_data_after", 64'(slot_data[2*DW +: DW]), 64'h4445);
    slot_req = '0; tick();

    // 5: SDRAM loop reset aborts in REQ and in WAIT
    set_addr(3, 22'h500); slot_req = 4'b1000;
    wait_req("t5a");
    loop_rst = 1'b1; tick();
    check("t5_abort_req", 64'(sdram_req), 64'd0);
    loop_rst = 1'b0;
    wait_req("t5b");
    check("t5_addr_b", 64'(sdram_addr), 64'h500);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    loop_rst = 1'b1; tick();
    check("t5_abort_wait", 64'(sdram_req), 64'd0);
    data_read = 32'h0000_5555; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    loop_rst = 1'b0;
    serve("t5c", 0, 0, 32'h0000_5556, a);
    check("t5_retry_addr", 64'(a), 64'h500);
    tick();
    check("t5_ok", 64'(slot_ok[3]), 64'd1);
    check("t5_data", 64'(slot_data[3*DW +: DW]), 64'h5556);
    slot_req = '0; tick();

    // 6: asynchronous reset during REQ
    set_addr(0, 22'h600); slot_req = 4'b0101;
    wait_req("t6a");
    check("t6_ok2_before", 64'(slot_ok[2]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_req", 64'(sdram_req), 64'd0);
    check("t6_async_ok", 64'(slot_ok), 64'd0);
    tick();
    rst_n = 1'b1;
    serve("t6b", 0, 0, 32'h0000_6000, a);
    check("t6_first_addr", 64'(a), 64'h600);
    check("t6_ok2_invalid", 64'(slot_ok[2]), 64'd0);
    serve("t6c", 0, 0, 32'h0000_6002, a);
    check("t6_refetch_addr", 64'(a), 64'h400);
    tick();
    check("t6_ok2_after", 64'(slot_ok[2]), 64'd1);
    slot_req = '0; tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
